// File: rtl/uart_tx_arbiter.sv
// Round-robin, per-message arbiter sharing one UART TX byte-write port among NUM_REQ clients; optional header byte via TX_ARB_HEADER_EN.
// Latency: grant registered one cycle after a request is seen in IDLE; bytes then pass combinationally lane -> tx_data_o.
// Backpressure: a byte moves only when owner valid and tx_rdy_i are both high; otherwise state, grant and count hold.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAX_LEN = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ack_o,
    output logic [NUM_REQ-1:0]     grant_o,
    input  logic                   tx_rdy_i,
    output logic                   tx_en_o,
    output logic [7:0]             tx_data_o,
    output logic                   busy_o,
    output logic                   trunc_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   grant_idx;
    logic [7:0]      byte_cnt;

    logic            pick_vld;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   scan_idx;
    logic            own_vld;
    logic            own_last;
    logic [7:0]      own_dat;
    logic            in_stream;
    logic            byte_acc;
    logic            at_max;
    logic            hdr_wr;

    // Round-robin pick: first valid lane scanning upward from rr_ptr, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = PW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!pick_vld && req_valid_i[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    // Select the owner's lane (valid, last, data).
    always_comb begin
        own_vld  = 1'b0;
        own_last = 1'b0;
        own_dat  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PW'(i)) begin
                own_vld  = req_valid_i[i];
                own_last = req_last_i[i];
                own_dat  = req_data_i[8*i +: 8];
            end
        end
    end

    assign in_stream = (state == ST_STREAM);
    assign byte_acc  = in_stream & own_vld & tx_rdy_i;
    // Counter holds bytes already accepted, so MAX_LEN-1 means this byte is the last allowed.
    assign at_max    = (byte_cnt == 8'(MAX_LEN - 1));

`ifdef TX_ARB_HEADER_EN
    assign hdr_wr = (state == ST_HEADER) & tx_rdy_i;
`else
    assign hdr_wr = 1'b0;
`endif

    assign tx_en_o   = byte_acc | hdr_wr;
    assign req_ack_o = byte_acc ? grant_o : '0;
    assign trunc_o   = byte_acc & at_max & ~own_last;
    assign busy_o    = (state != ST_IDLE);

    // Transmit data: header tag while in HEADER, owner lane while streaming, zero when idle.
    always_comb begin
        tx_data_o = 8'h00;
`ifdef TX_ARB_HEADER_EN
        if (state == ST_HEADER) begin
            tx_data_o = 8'hA0 | 8'(grant_idx);
        end
`endif
        if (in_stream) begin
            tx_data_o = own_dat;
        end
    end

    // Grant FSM: arbitrate in IDLE, optional header, stream until last or length cap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            grant_o   <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
            byte_cnt  <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant_o   <= NUM_REQ'(1) << pick_idx;
                        grant_idx <= pick_idx;
                        byte_cnt  <= 8'h00;
`ifdef TX_ARB_HEADER_EN
                        state     <= ST_HEADER;
`else
                        state     <= ST_STREAM;
`endif
                    end
                end
`ifdef TX_ARB_HEADER_EN
                ST_HEADER: begin
                    if (tx_rdy_i) begin
                        state <= ST_STREAM;
                    end
                end
`endif
                ST_STREAM: begin
                    if (byte_acc) begin
                        if (own_last || at_max) begin
                            state    <= ST_IDLE;
                            grant_o  <= '0;
                            byte_cnt <= 8'h00;
                            rr_ptr   <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a message-level reference model.
// Latency: model predicts outputs each cycle from its owner/pointer/count bookkeeping and the driven inputs.
// Backpressure: tx_rdy_i randomized with forced multi-cycle stalls; requesters hold lanes until acked.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int ML = 4;
`ifdef TX_ARB_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [N-1:0]   req_valid_i;
    logic [8*N-1:0] req_data_i;
    logic [N-1:0]   req_last_i;
    logic [N-1:0]   req_ack_o;
    logic [N-1:0]   grant_o;
    logic           tx_rdy_i;
    logic           tx_en_o;
    logic [7:0]     tx_data_o;
    logic           busy_o;
    logic           trunc_o;

    always #5 clk_i = ~clk_i;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_LEN(ML)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ack_o   (req_ack_o),
        .grant_o     (grant_o),
        .tx_rdy_i    (tx_rdy_i),
        .tx_en_o     (tx_en_o),
        .tx_data_o   (tx_data_o),
        .busy_o      (busy_o),
        .trunc_o     (trunc_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Requester-side message queues (byte + last flag per entry).
    byte unsigned qd[N][$];
    bit           ql[N][$];
    logic [N-1:0] vld_r;
    logic [N-1:0] ack_seen;
    logic         rdy;
    bit           gen_on;
    bit           rand_vld;
    bit           rand_rdy;
    int           stall_cnt;

    // Reference model: current owner (-1 idle), header pending, bytes in grant, rr pointer.
    int m_owner;
    int m_cnt;
    int m_ptr;
    bit m_hdr;

    // Observed-traffic counters for scenario-level checks.
    int n_tx_en;
    int n_trunc;
    int lane_acks[N];
    int lane_msgs[N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_msg(input int r, input int len);
        for (int b = 0; b < len; b++) begin
            qd[r].push_back(8'($urandom_range(0, 255)));
            ql[r].push_back(b == len - 1);
        end
    endtask

    task automatic push_byte(input int r, input byte unsigned d, input bit last);
        qd[r].push_back(d);
        ql[r].push_back(last);
    endtask

    task automatic drive_lanes();
        for (int i = 0; i < N; i++) begin
            req_valid_i[i]       = vld_r[i];
            req_data_i[8*i +: 8] = vld_r[i] ? qd[i][0] : 8'h00;
            req_last_i[i]        = vld_r[i] ? ql[i][0] : 1'b0;
        end
    endtask

    task automatic check_quiet(input string pfx);
        check_eq({pfx, "_grant"}, 32'(grant_o), 32'd0);
        check_eq({pfx, "_busy"},  32'(busy_o),  32'd0);
        check_eq({pfx, "_en"},    32'(tx_en_o), 32'd0);
        check_eq({pfx, "_ack"},   32'(req_ack_o), 32'd0);
        check_eq({pfx, "_trunc"}, 32'(trunc_o), 32'd0);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
        m_hdr   = 1'b0;
    endtask

    // Compare DUT against model for this cycle, then advance the model over the coming edge.
    task automatic check_model();
        int o;
        logic [N-1:0] one;
        logic [N-1:0] eg;
        logic [N-1:0] ea;
        logic         een;
        logic         etr;
        logic [7:0]   ed;
        o   = m_owner;
        one = 1;
        eg  = (o >= 0) ? (one << o) : '0;
        ea  = '0;
        een = 1'b0;
        etr = 1'b0;
        ed  = 8'h00;
        if (o >= 0) begin
            if (m_hdr) begin
                een = rdy;
                ed  = 8'hA0 | 8'(o);
            end else begin
                een = vld_r[o] & rdy;
                if (een) begin
                    ed  = qd[o][0];
                    ea  = eg;
                    etr = !ql[o][0] && (m_cnt == ML - 1);
                end
            end
        end
        check_eq("busy",  32'(busy_o),    32'(o >= 0));
        check_eq("grant", 32'(grant_o),   32'(eg));
        check_eq("tx_en", 32'(tx_en_o),   32'(een));
        check_eq("ack",   32'(req_ack_o), 32'(ea));
        check_eq("trunc", 32'(trunc_o),   32'(etr));
        if (een) check_eq("tx_data", 32'(tx_data_o), 32'(ed));

        if (o < 0) begin
            if (vld_r != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && vld_r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                end
                m_hdr = (HDR != 0);
                m_cnt = 0;
            end
        end else if (m_hdr) begin
            if (rdy) m_hdr = 1'b0;
        end else if (een) begin
            m_cnt++;
            if (ql[o][0] || m_cnt == ML) begin
                m_owner = -1;
                m_ptr   = (o + 1) % N;
            end
        end
    endtask

    // One clock: update requesters from last acks, choose tx_rdy_i, check at negedge.
    task automatic step();
        @(posedge clk_i);
        #1;
        for (int i = 0; i < N; i++) begin
            if (ack_seen[i]) begin
                if (qd[i].size() > 0) begin
                    void'(qd[i].pop_front());
                    void'(ql[i].pop_front());
                end
                vld_r[i] = 1'b0;
            end
        end
        if (gen_on) begin
            for (int i = 0; i < N; i++) begin
                if (qd[i].size() == 0 && $urandom_range(0, 7) == 0) push_msg(i, $urandom_range(1, 6));
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!vld_r[i] && qd[i].size() > 0 && (!rand_vld || $urandom_range(0, 3) != 0)) vld_r[i] = 1'b1;
        end
        if (stall_cnt > 0) begin
            rdy = 1'b0;
            stall_cnt--;
        end else if (rand_rdy) begin
            if ($urandom_range(0, 39) == 0) begin
                stall_cnt = 4;
                rdy       = 1'b0;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
        end else begin
            rdy = 1'b1;
        end
        tx_rdy_i = rdy;
        drive_lanes();
        @(negedge clk_i);
        check_model();
        if (tx_en_o) n_tx_en++;
        if (trunc_o) n_trunc++;
        for (int i = 0; i < N; i++) begin
            if (req_ack_o[i]) begin
                lane_acks[i]++;
                if (req_last_i[i]) lane_msgs[i]++;
            end
        end
        ack_seen = req_ack_o;
    endtask

    function automatic bit pending();
        bit p;
        p = (m_owner >= 0) || (vld_r != '0) || (ack_seen != '0) || busy_o;
        for (int i = 0; i < N; i++) if (qd[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic run_until_idle(input string tag, input int budget);
        int c;
        c = 0;
        while (pending() && c < budget) begin
            step();
            c++;
        end
        check_eq(tag, 32'(pending()), 32'd0);
    endtask

    int base_en, base_tr, base_m0, base_m2, base_a2, base_a3, guard;

    initial begin
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        tx_rdy_i    = 1'b1;
        vld_r       = '0;
        ack_seen    = '0;
        rdy         = 1'b1;
        gen_on      = 1'b0;
        rand_vld    = 1'b0;
        rand_rdy    = 1'b0;
        stall_cnt   = 0;
        n_tx_en     = 0;
        n_trunc     = 0;
        for (int i = 0; i < N; i++) begin
            lane_acks[i] = 0;
            lane_msgs[i] = 0;
        end
        model_reset();

        // Reset state.
        #2;
        check_quiet("rst");
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Single requester, three bytes, ready always high.
        base_en = n_tx_en;
        push_byte(1, 8'h11, 1'b0);
        push_byte(1, 8'h22, 1'b0);
        push_byte(1, 8'h33, 1'b1);
        run_until_idle("single_drain", 40);
        check_eq("single_writes", 32'(n_tx_en - base_en), 32'(3 + HDR));
        check_eq("single_acks", 32'(lane_acks[1]), 32'd3);

        // Two competing requesters over ten rounds.
        base_m0 = lane_msgs[0];
        base_m2 = lane_msgs[2];
        for (int r = 0; r < 10; r++) begin
            push_msg(0, 2);
            push_msg(2, 2);
            run_until_idle("fair_drain", 60);
        end
        check_eq("fair_req0", 32'(lane_msgs[0] - base_m0), 32'd10);
        check_eq("fair_req2", 32'(lane_msgs[2] - base_m2), 32'd10);

        // Five-cycle ready stall in mid-message.
        base_en = n_tx_en;
        push_msg(0, 3);
        step();
        step();
        stall_cnt = 5;
        run_until_idle("stall_drain", 60);
        check_eq("stall_writes", 32'(n_tx_en - base_en), 32'(3 + HDR));

        // Six-byte message against a four-byte cap.
        base_en = n_tx_en;
        base_tr = n_trunc;
        push_msg(3, 6);
        run_until_idle("trunc_drain", 60);
        check_eq("trunc_pulses", 32'(n_trunc - base_tr), 32'd1);
        check_eq("trunc_writes", 32'(n_tx_en - base_en), 32'(6 + 2 * HDR));

        // Header/short message on lane 2.
        base_en = n_tx_en;
        base_a2 = lane_acks[2];
        push_byte(2, 8'h5A, 1'b1);
        run_until_idle("hdr_drain", 40);
        check_eq("hdr_writes", 32'(n_tx_en - base_en), 32'(1 + HDR));
        check_eq("hdr_acks", 32'(lane_acks[2] - base_a2), 32'd1);

        // Randomized traffic, then drain.
        gen_on   = 1'b1;
        rand_vld = 1'b1;
        rand_rdy = 1'b1;
        repeat (600) step();
        gen_on   = 1'b0;
        rand_vld = 1'b0;
        rand_rdy = 1'b0;
        run_until_idle("rand_drain", 400);

        // Reset in the middle of a five-byte message after two bytes are accepted.
        base_a3 = lane_acks[3];
        push_msg(3, 5);
        guard = 0;
        while ((lane_acks[3] - base_a3) < 2 && guard < 30) begin
            step();
            guard++;
        end
        check_eq("mid_two_acks", 32'(lane_acks[3] - base_a3), 32'd2);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        check_quiet("mid_rst");
        for (int i = 0; i < N; i++) begin
            qd[i].delete();
            ql[i].delete();
        end
        vld_r    = '0;
        ack_seen = '0;
        drive_lanes();
        model_reset();
        @(posedge clk_i);
        #1;
        check_quiet("mid_hold");
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        base_m0 = lane_msgs[0];
        push_msg(2, 1);
        push_msg(0, 1);
        step();
        step();
        check_eq("post_rst_owner", 32'(grant_o), 32'd1);
        run_until_idle("post_rst_drain", 40);
        check_eq("post_rst_req0", 32'(lane_msgs[0] - base_m0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
